// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
package pipe_pkg;

  // Occupancy-encoded state: the numeric value equals entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Default payload split for the EXE->MEM boundary.
  localparam int EXE_MEM_CTRL_W = 3;   // DataMemWE + WriteDataSrc[1:0]
  localparam int EXE_MEM_DATA_W = 69;  // ALURes + Reg2DataOut + WriteRegSrc

  // Power-on values shared with the older fixed latches.
  localparam logic INIT_VALID = 1'b0;
  localparam logic INIT_READY = 1'b1;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag, side-effecting control bits, data bits.
// Clearing always zeroes control so a bubble never carries a write enable;
// data is zeroed on clear only when zero_data_i is set.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXE_MEM_CTRL_W,
  parameter int DATA_W = EXE_MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              zero_data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Entry register: clear wins over load so a flush discards a same-cycle input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= INIT_VALID;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (zero_data_i) begin
        data_q <= '0;
      end
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline register with valid/ready handshake and a one-entry skid buffer.
// The main slot drives the outputs; the skid slot catches the entry that
// arrives in the cycle the downstream stalls, so in_ready can be a flop.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W          = EXE_MEM_CTRL_W,
  parameter int DATA_W          = EXE_MEM_DATA_W,
  parameter int FLUSH_ZERO_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_e state_q, state_d;
  logic   in_ready_q;

  logic   in_fire, out_fire;
  logic   main_load, main_clear, main_from_skid;
  logic   skid_load, skid_clear;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  localparam logic ZERO_DATA = (FLUSH_ZERO_DATA != 0);

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid & out_ready;

  // Next-state and slot control; flush overrides every handshake.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_d    = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; in_ready is registered so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= INIT_READY;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk         (clk),
    .rst         (rst),
    .load_i      (main_load),
    .clear_i     (main_clear),
    .zero_data_i (ZERO_DATA),
    .ctrl_i      (main_ctrl_in),
    .data_i      (main_data_in),
    .valid_o     (main_valid),
    .ctrl_o      (main_ctrl),
    .data_o      (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .load_i      (skid_load),
    .clear_i     (skid_clear),
    .zero_data_i (ZERO_DATA),
    .ctrl_i      (in_ctrl),
    .data_i      (in_data),
    .valid_o     (skid_valid),
    .ctrl_o      (skid_ctrl),
    .data_o      (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted entries are queued, the
// queue head must be on the outputs, and occupancy must match the queue.
module tb_pipe_skid_stage;

  localparam int CW  = 3;
  localparam int DW  = 69;
  localparam int FZD = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_xfer   = 0;

  pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_ZERO_DATA(FZD)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Main slot invalid while skid slot valid must never happen.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      assert (!(dut.skid_valid && !dut.main_valid))
      else begin
        failures++;
        $display("FAIL illegal_state: main_valid=%b skid_valid=%b", dut.main_valid, dut.skid_valid);
      end
    end
  end

  // Record handshakes before the edge, advance, then check outputs against the scoreboard.
  task automatic cycle();
    logic infire, outfire;
    ent_t e;
    infire  = ((in_valid && in_ready) === 1'b1);
    outfire = ((out_valid && out_ready) === 1'b1);
    if (rst !== 1'b1) begin
      sb.delete();
    end else begin
      if (outfire) begin
        if (sb.size() == 0) begin
          check_val("spurious_out", out_valid, 1'b0);
        end else begin
          n_xfer++;
          $display("xfer %0d ctrl=%0h data=%0h", n_xfer, out_ctrl, out_data);
          void'(sb.pop_front());
        end
      end
      if (flush) begin
        sb.delete();
      end else if (infire) begin
        e.c = in_ctrl;
        e.d = in_data;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_val("occupancy", occupancy, sb.size());
    check_val("in_ready", in_ready, sb.size() < 2);
    check_val("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check_val("out_ctrl", out_ctrl, sb[0].c);
      check_val("out_data", out_data, sb[0].d);
    end else begin
      check_val("bubble_ctrl", out_ctrl, 0);
      check_val("bubble_data", out_data, 0);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    // Reset with a valid input present: nothing may be captured.
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 3'b111, 69'h1_2345_6789_ABCD_EF01);
    cycle();
    cycle();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_ctrl", out_ctrl, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_occupancy", occupancy, 0);
    rst = 1'b1;
    drive(1'b0, '0, '0);
    cycle();

    // Streaming 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i), DW'(i));
      cycle();
      check_val("stream_data", out_data, DW'(i));
      check_val("stream_in_ready", in_ready, 1);
      check_val("stream_occ", occupancy, 1);
    end
    drive(1'b0, '0, '0);
    cycle();

    // Backpressure: A, B fill the stage; C waits at the source.
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 69'hA);
    cycle();
    check_val("bp_occ_a", occupancy, 1);
    drive(1'b1, 3'd2, 69'hB);
    cycle();
    check_val("bp_occ_b", occupancy, 2);
    check_val("bp_in_ready_b", in_ready, 0);
    drive(1'b1, 3'd3, 69'hC);
    cycle();
    cycle();
    check_val("bp_hold_data", out_data, 69'hA);
    out_ready = 1'b1;
    cycle();
    check_val("bp_head_b", out_data, 69'hB);
    cycle();
    check_val("bp_head_c", out_data, 69'hC);
    drive(1'b0, '0, '0);
    cycle();
    cycle();

    // Flush while FULL, with a simultaneous input that must be dropped.
    out_ready = 1'b0;
    drive(1'b1, 3'b101, 69'h11);
    cycle();
    drive(1'b1, 3'b101, 69'h22);
    cycle();
    check_val("fl_full_occ", occupancy, 2);
    flush = 1'b1;
    drive(1'b1, 3'b101, 69'h33);
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check_val("fl_out_valid", out_valid, 0);
    check_val("fl_out_ctrl", out_ctrl, 0);
    check_val("fl_out_data", out_data, 0);
    check_val("fl_occ", occupancy, 0);
    check_val("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Flush during a transfer: old entry consumed, new input discarded.
    drive(1'b1, 3'b001, 69'h44);
    cycle();
    flush = 1'b1;
    drive(1'b1, 3'b010, 69'h55);
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check_val("flx_out_valid", out_valid, 0);
    check_val("flx_occ", occupancy, 0);
    cycle();

    // Reset while FULL and stalled, then 1-cycle latency afterwards.
    out_ready = 1'b0;
    drive(1'b1, 3'b110, 69'h66);
    cycle();
    drive(1'b1, 3'b011, 69'h77);
    cycle();
    rst = 1'b0;
    drive(1'b0, '0, '0);
    cycle();
    check_val("rr_occ", occupancy, 0);
    check_val("rr_in_ready", in_ready, 1);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b100, 69'h88);
    cycle();
    check_val("rr_latency", out_data, 69'h88);
    drive(1'b0, '0, '0);
    cycle();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 120; i++) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom), {5'($urandom), $urandom, $urandom});
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) cycle();
    check_val("drained", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
